// File: rtl/regfile_mp.sv
// Multi-write-port register file with a sequential clear after reset.
// Two combinational read ports and two write ports. When both write ports
// target the same address, port B wins. Optional same-cycle write-to-read
// bypass and an optional hardwired zero register. After reset the array is
// cleared one entry per cycle; until that finishes, reads return 0, writes
// are discarded and each discarded write raises a one-cycle wr_drop pulse.
module regfile_mp #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s1,
    input  logic [ADDR_W-1:0] s2,
    output logic [WIDTH-1:0]  rs,
    output logic [WIDTH-1:0]  rt,
    input  logic [ADDR_W-1:0] d,
    input  logic [WIDTH-1:0]  rd,
    input  logic              rwe,
    input  logic [ADDR_W-1:0] d2,
    input  logic [WIDTH-1:0]  rd2,
    input  logic              rwe2,
    output logic              ready,
    output logic              wr_drop
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              ready_q;
    logic              wr_drop_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              wa_en;
    logic              wb_en;
    logic              s1_zero;
    logic              s2_zero;

    // Write enables with the zero-register address masked out
    always_comb begin
        wa_en   = rwe  && !((ZERO_REG != 0) && (d  == '0));
        wb_en   = rwe2 && !((ZERO_REG != 0) && (d2 == '0));
        s1_zero = (ZERO_REG != 0) && (s1 == '0);
        s2_zero = (ZERO_REG != 0) && (s2 == '0);
    end

    // Clear-sequence FSM: walks the counter over every entry, then flags ready
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt       <= cnt + ADDR_W'(1);
                    wr_drop_q <= rwe | rwe2;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    wr_drop_q <= 1'b0;
                end
                default: begin
                    state     <= CLEAR;
                    cnt       <= '0;
                    ready_q   <= 1'b0;
                    wr_drop_q <= 1'b0;
                end
            endcase
        end
    end

    // Array update: clear one entry per cycle, else port A then port B (B wins)
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else begin
                if (wa_en) mem[d]  <= rd;
                if (wb_en) mem[d2] <= rd2;
            end
        end
    end

    // Read port 1: gated by ready, zero register first, then optional bypass
    always_comb begin
        rs = '0;
        if (ready_q && !s1_zero) begin
            rs = mem[s1];
            if (BYPASS != 0) begin
                if (rwe2 && (d2 == s1))
                    rs = rd2;
                else if (rwe && (d == s1))
                    rs = rd;
            end
        end
    end

    // Read port 2: same rules as read port 1
    always_comb begin
        rt = '0;
        if (ready_q && !s2_zero) begin
            rt = mem[s2];
            if (BYPASS != 0) begin
                if (rwe2 && (d2 == s2))
                    rt = rd2;
                else if (rwe && (d == s2))
                    rt = rd;
            end
        end
    end

    assign ready   = ready_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: one bypassing instance and one
// non-bypassing instance share all inputs and are checked side by side.
module tb_regfile_mp;

    logic        clock;
    logic        reset;
    logic [4:0]  s1, s2, d, d2;
    logic [31:0] rd, rd2;
    logic        rwe, rwe2;
    logic [31:0] rs, rt, rs_nb, rt_nb;
    logic        ready, wr_drop, ready_nb, wr_drop_nb;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned n;

    regfile_mp #(
        .WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clock(clock), .reset(reset), .s1(s1), .s2(s2), .rs(rs), .rt(rt),
        .d(d), .rd(rd), .rwe(rwe), .d2(d2), .rd2(rd2), .rwe2(rwe2),
        .ready(ready), .wr_drop(wr_drop)
    );

    regfile_mp #(
        .WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)
    ) dut_nb (
        .clock(clock), .reset(reset), .s1(s1), .s2(s2), .rs(rs_nb), .rt(rt_nb),
        .d(d), .rd(rd), .rwe(rwe), .d2(d2), .rd2(rd2), .rwe2(rwe2),
        .ready(ready_nb), .wr_drop(wr_drop_nb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        rwe = 1'b0; rwe2 = 1'b0;
        d = '0; d2 = '0; rd = '0; rd2 = '0;
        s1 = '0; s2 = '0;
    endtask

    // Count cycles after reset deassert until ready, bounded
    task automatic wait_ready(output int unsigned cycles);
        cycles = 0;
        while (!ready && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, ready}, 32'd0);
        check("wr_drop_after_reset", {31'd0, wr_drop}, 32'd0);

        wait_ready(n);
        check("clear_cycles", n, 32'd32);
        check("ready_nb_in_step", {31'd0, ready_nb}, 32'd1);

        for (int unsigned a = 0; a < 32; a++) begin
            s1 = 5'(a); s2 = 5'(31 - a);
            #1;
            check($sformatf("rs_clear_%0d", a), rs, 32'd0);
            check($sformatf("rt_clear_%0d", a), rt, 32'd0);
        end

        // Single write with same-cycle bypass
        s1 = 5'd5; d = 5'd5; rd = 32'hDEADBEEF; rwe = 1'b1;
        #1;
        check("bypass_rs_same_cycle", rs, 32'hDEADBEEF);
        check("nobypass_rs_same_cycle", rs_nb, 32'd0);
        tick();
        rwe = 1'b0;
        #1;
        check("rs_after_write", rs, 32'hDEADBEEF);
        check("rs_nb_after_write", rs_nb, 32'hDEADBEEF);
        check("wr_drop_ready_write", {31'd0, wr_drop}, 32'd0);

        // Both ports to the same address: port B wins
        d = 5'd7; d2 = 5'd7; rd = 32'h1111; rd2 = 32'h2222;
        rwe = 1'b1; rwe2 = 1'b1; s2 = 5'd7;
        #1;
        check("bypass_rt_collision", rt, 32'h2222);
        check("nobypass_rt_collision", rt_nb, 32'd0);
        tick();
        rwe = 1'b0; rwe2 = 1'b0;
        #1;
        check("rt_collision_stored", rt, 32'h2222);
        check("rt_nb_collision_stored", rt_nb, 32'h2222);

        // Two independent writes, each port bypassed to a different reader
        d = 5'd9; rd = 32'h99; d2 = 5'd10; rd2 = 32'hAA;
        rwe = 1'b1; rwe2 = 1'b1; s1 = 5'd9; s2 = 5'd10;
        #1;
        check("bypass_rs_porta", rs, 32'h99);
        check("bypass_rt_portb", rt, 32'hAA);
        tick();
        rwe = 1'b0; rwe2 = 1'b0;
        #1;
        check("rs_porta_stored", rs_nb, 32'h99);
        check("rt_portb_stored", rt_nb, 32'hAA);

        // Zero register ignores writes and never bypasses
        d = 5'd0; rd = 32'hFFFFFFFF; rwe = 1'b1;
        d2 = 5'd0; rd2 = 32'h12345678; rwe2 = 1'b1;
        s1 = 5'd0; s2 = 5'd0;
        #1;
        check("zero_rs_same_cycle", rs, 32'd0);
        check("zero_rt_same_cycle", rt, 32'd0);
        tick();
        rwe = 1'b0; rwe2 = 1'b0;
        #1;
        check("zero_rs_next_cycle", rs, 32'd0);
        check("zero_wr_drop", {31'd0, wr_drop}, 32'd0);

        // Non-bypassed read returns the pre-edge value
        d = 5'd3; rd = 32'hA5; rwe = 1'b1; s1 = 5'd3;
        #1;
        check("nobypass_old_value", rs_nb, 32'd0);
        tick();
        rwe = 1'b0;
        #1;
        check("nobypass_new_value", rs_nb, 32'hA5);

        // Reset from READY, then reassert at clear count 10
        reset = 1'b1;
        tick();
        reset = 1'b0;
        s1 = 5'd5;
        #1;
        check("ready_low_after_reset_in_ready", {31'd0, ready}, 32'd0);
        check("rs_gated_during_clear", rs, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("still_clearing_at_10", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Write during clear is dropped and flagged once
        d = 5'd20; rd = 32'h1234; rwe = 1'b1;
        tick();
        rwe = 1'b0;
        #1;
        check("wr_drop_pulse", {31'd0, wr_drop}, 32'd1);
        tick();
        check("wr_drop_single", {31'd0, wr_drop}, 32'd0);
        check("ready_low_mid_clear", {31'd0, ready}, 32'd0);
        wait_ready(n);
        check("clear_cycles_after_restart", n + 2, 32'd32);
        s1 = 5'd20; s2 = 5'd5;
        #1;
        check("dropped_addr_reads_zero", rs, 32'd0);
        check("cleared_addr5_reads_zero", rt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
